instruction_fetch_unit: RTL and testbench

- Front end of the pipelined 16-bit TSC core.
- Owns the PC and drives the instruction-memory read handshake.
- Delivers fetched words into the IF/ID slot, presenting opcode and func_code to the decode/control stage.
- Supports decode stall (one-entry skid buffer), branch/jump redirect with in-flight response discard, and HLT stop.

---
 rtl/instruction_fetch_unit_pkg.sv | 26 ++
 rtl/instruction_fetch_unit_skid.sv | 67 ++++++
 rtl/opcodes.sv | 13 +
 rtl/instruction_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
`include "opcodes.sv"
`default_nettype none
// ============================================================================
// instruction_fetch_unit_pkg
// Types and constants shared by the instruction fetch unit and its skid
// buffer: fetch FSM state type, HLT recognition helper.
// Revision: 1.0 - initial release
// ============================================================================
package instruction_fetch_unit_pkg;

  localparam logic [3:0] c_HLT_OP   = `HLT_OP;
  localparam logic [5:0] c_HLT_FUNC = `HLT_FUNC;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // normal fetching
    ST_DROP  = 2'd1,  // waiting out a stale request after a redirect
    ST_HALT  = 2'd2   // HLT captured, no further requests
  } if_state_t;

  // True when the word is the HLT instruction (opcode and func both match).
  function automatic logic is_hlt(input logic [15:0] word);
    return (word[15:12] == c_HLT_OP) && (word[5:0] == c_HLT_FUNC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_skid.sv
`default_nettype none
// ============================================================================
// if_skid_buffer
// One-entry holding register for a fetched word that arrives while the IF/ID
// slot is stalled.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_flush        : discard contents (redirect), highest priority
//   i_drain        : contents moved to the IF/ID slot this cycle
//   i_load         : capture i_data / i_pc
//   o_valid/o_data/o_pc : buffered entry
// Revision: 1.0 - initial release
// ============================================================================
module if_skid_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned WORD = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_flush,
  input  logic            i_drain,
  input  logic            i_load,
  input  logic [WORD-1:0] i_data,
  input  logic [WORD-1:0] i_pc,
  output logic            o_valid,
  output logic [WORD-1:0] o_data,
  output logic [WORD-1:0] o_pc
);

  logic            valid_q, valid_d;
  logic [WORD-1:0] data_q,  data_d;
  logic [WORD-1:0] pc_q,    pc_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (i_drain) begin
      valid_d = 1'b0;
    end else if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
      pc_d    = i_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_pc    = pc_q;

endmodule
`default_nettype wire

// File: rtl/opcodes.sv
`default_nettype none
// ============================================================================
// opcodes.sv
// Shared TSC opcode / function-code constants, textually included by any
// file that needs to recognise specific instructions.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef OPCODES_V
`define OPCODES_V
`define HLT_OP   4'd15
`define HLT_FUNC 6'd29
`endif
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// instruction_fetch_unit
// Front end of the pipelined 16-bit TSC core. Owns the PC, runs the
// instruction-memory read handshake and fills the IF/ID slot. Supports decode
// stall via a one-entry skid buffer, redirect with discard of an in-flight
// response, and stop on HLT.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   i_readM, i_address      : memory read request / word address
//   i_data, inputReady      : memory response data / strobe
//   id_stall                : decode cannot accept, slot must hold
//   redirect_valid/_pc      : flush and refetch from redirect_pc
//   inst_valid, inst, inst_pc : IF/ID slot contents
//   opcode, func_code       : combinational fields of inst
//   halted                  : HLT fetched, fetching stopped
// Revision: 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned     WORD     = 16,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            i_readM,
  output logic [WORD-1:0] i_address,
  input  logic [WORD-1:0] i_data,
  input  logic            inputReady,
  input  logic            id_stall,
  input  logic            redirect_valid,
  input  logic [WORD-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [WORD-1:0] inst,
  output logic [WORD-1:0] inst_pc,
  output logic [3:0]      opcode,
  output logic [5:0]      func_code,
  output logic            halted
);

  localparam logic [WORD-1:0] c_PC_INC = {{(WORD-1){1'b0}}, 1'b1};

  if_state_t       state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] drop_addr_q, drop_addr_d;
  logic [WORD-1:0] inst_q, inst_d;
  logic [WORD-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;

  logic            w_buf_valid;
  logic [WORD-1:0] w_buf_data;
  logic [WORD-1:0] w_buf_pc;
  logic            w_req;
  logic            w_slot_free;
  logic            w_accept;
  logic            w_drain;
  logic            w_buf_load;

  // A request is open whenever FETCH has nowhere pending to park data, or
  // while DROP waits out the stale response.
  assign w_req       = ((state_q == ST_FETCH) && !w_buf_valid) || (state_q == ST_DROP);
  // Gating with reset_n keeps the request low for the whole time reset is held.
  assign i_readM     = reset_n && w_req;
  assign i_address   = (state_q == ST_DROP) ? drop_addr_q : pc_q;

  assign w_slot_free = !inst_valid_q || !id_stall;
  assign w_accept    = (state_q == ST_FETCH) && w_req && inputReady && !redirect_valid;
  assign w_drain     = w_buf_valid && !id_stall && !redirect_valid;
  assign w_buf_load  = w_accept && !w_slot_free;

  if_skid_buffer #(
    .WORD (WORD)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (redirect_valid),
    .i_drain (w_drain),
    .i_load  (w_buf_load),
    .i_data  (i_data),
    .i_pc    (pc_q),
    .o_valid (w_buf_valid),
    .o_data  (w_buf_data),
    .o_pc    (w_buf_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    if (redirect_valid) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      // An unanswered request must still be consumed before refetching.
      if (w_req && !inputReady) begin
        state_d     = ST_DROP;
        drop_addr_d = i_address;
      end else begin
        state_d     = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (w_accept) begin
            pc_d = pc_q + c_PC_INC;
            if (is_hlt(i_data)) begin
              state_d = ST_HALT;
            end
          end
        end
        ST_DROP: begin
          if (inputReady) begin
            state_d = ST_FETCH;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase

      // Buffered word is older than anything arriving now, so it wins.
      if (w_drain) begin
        inst_d       = w_buf_data;
        inst_pc_d    = w_buf_pc;
        inst_valid_d = 1'b1;
      end else if (w_accept && w_slot_free) begin
        inst_d       = i_data;
        inst_pc_d    = pc_q;
        inst_valid_d = 1'b1;
      end else if (w_slot_free && !w_buf_valid) begin
        inst_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      drop_addr_q  <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign opcode     = inst_q[15:12];
  assign func_code  = inst_q[5:0];
  assign halted     = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_instruction_fetch_unit
// Directed per-cycle vector table for instruction_fetch_unit plus hand-written
// reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        inputReady;
  logic        id_stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [3:0]  opcode;
  logic [5:0]  func_code;
  logic        halted;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .WORD     (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_readM        (i_readM),
    .i_address      (i_address),
    .i_data         (i_data),
    .inputReady     (inputReady),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .func_code      (func_code),
    .halted         (halted)
  );

  typedef struct {
    logic        rdy;
    logic [15:0] data;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_iv;
    logic [15:0] e_inst;
    logic [15:0] e_ipc;
    logic        e_halt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic rdy, input logic [15:0] data,
                              input logic stall, input logic redir,
                              input logic [15:0] rpc, input logic e_rd,
                              input logic [15:0] e_addr, input logic e_iv,
                              input logic [15:0] e_inst, input logic [15:0] e_ipc,
                              input logic e_halt);
    vec_t v;
    v.rdy = rdy; v.data = data; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst;
    v.e_ipc = e_ipc; v.e_halt = e_halt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //           rdy data     stl red rpc       rd addr     iv inst     ipc      hlt
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0)); // 0
    tv.push_back(mk(1, 16'h6001, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0)); // 1
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0001, 1, 16'h6001, 16'h0000, 0)); // 2
    tv.push_back(mk(1, 16'h6102, 0, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 16'h0000, 0)); // 3
    tv.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h6102, 16'h0001, 0)); // 4
    tv.push_back(mk(1, 16'h6203, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h6102, 16'h0001, 0)); // 5
    tv.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h6102, 16'h0001, 0)); // 6
    tv.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h6102, 16'h0001, 0)); // 7
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h6102, 16'h0001, 0)); // 8
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0003, 1, 16'h6203, 16'h0002, 0)); // 9
    tv.push_back(mk(1, 16'h7004, 0, 0, 16'h0000, 1, 16'h0003, 0, 16'h0000, 16'h0000, 0)); // 10
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'h7004, 16'h0003, 0)); // 11
    tv.push_back(mk(1, 16'h6105, 0, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000, 16'h0000, 0)); // 12
    tv.push_back(mk(0, 16'h0000, 0, 1, 16'h0040, 1, 16'h0005, 1, 16'h6105, 16'h0004, 0)); // 13
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000, 0)); // 14
    tv.push_back(mk(1, 16'h6AAA, 0, 0, 16'h0000, 1, 16'h0005, 0, 16'h0000, 16'h0000, 0)); // 15
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000, 0)); // 16
    tv.push_back(mk(1, 16'h6140, 0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000, 0)); // 17
    tv.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0041, 1, 16'h6140, 16'h0040, 0)); // 18
    tv.push_back(mk(1, 16'h6BBB, 1, 1, 16'h0080, 1, 16'h0041, 1, 16'h6140, 16'h0040, 0)); // 19
    tv.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000, 16'h0000, 0)); // 20
    tv.push_back(mk(1, 16'h6180, 0, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000, 16'h0000, 0)); // 21
    tv.push_back(mk(0, 16'h0000, 0, 1, 16'h0010, 1, 16'h0081, 1, 16'h6180, 16'h0080, 0)); // 22
    tv.push_back(mk(1, 16'h6CCC, 0, 0, 16'h0000, 1, 16'h0081, 0, 16'h0000, 16'h0000, 0)); // 23
    tv.push_back(mk(1, 16'hF01D, 0, 0, 16'h0000, 1, 16'h0010, 0, 16'h0000, 16'h0000, 0)); // 24
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hF01D, 16'h0010, 1)); // 25
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1)); // 26
    tv.push_back(mk(0, 16'h0000, 0, 1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1)); // 27
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000, 16'h0000, 0)); // 28
    tv.push_back(mk(1, 16'h6220, 0, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000, 16'h0000, 0)); // 29
    tv.push_back(mk(1, 16'hF01D, 1, 0, 16'h0000, 1, 16'h0021, 1, 16'h6220, 16'h0020, 0)); // 30
    tv.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h6220, 16'h0020, 1)); // 31
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h6220, 16'h0020, 1)); // 32
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hF01D, 16'h0021, 1)); // 33
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1)); // 34
    tv.push_back(mk(0, 16'h0000, 0, 1, 16'h0030, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1)); // 35
    tv.push_back(mk(1, 16'h6330, 0, 0, 16'h0000, 1, 16'h0030, 0, 16'h0000, 16'h0000, 0)); // 36
    tv.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0031, 1, 16'h6330, 16'h0030, 0)); // 37

    // Reset state
    reset_n = 1'b0; inputReady = 1'b0; i_data = '0; id_stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);
    chk("reset readM",  {15'b0, i_readM},    16'h0000);
    chk("reset ival",   {15'b0, inst_valid}, 16'h0000);
    chk("reset inst",   inst,                16'h0000);
    chk("reset ipc",    inst_pc,             16'h0000);
    chk("reset halted", {15'b0, halted},     16'h0000);
    reset_n = 1'b1;

    // Per-cycle table: inputs driven at negedge, outputs checked 1 time unit later
    for (int i = 0; i < tv.size(); i++) begin
      vec_t v;
      v = tv[i];
      inputReady = v.rdy; i_data = v.data; id_stall = v.stall;
      redirect_valid = v.redir; redirect_pc = v.rpc;
      #1;
      chk($sformatf("row%0d readM", i),  {15'b0, i_readM},    {15'b0, v.e_rd});
      chk($sformatf("row%0d ival", i),   {15'b0, inst_valid}, {15'b0, v.e_iv});
      chk($sformatf("row%0d halted", i), {15'b0, halted},     {15'b0, v.e_halt});
      if (v.e_rd) chk($sformatf("row%0d addr", i), i_address, v.e_addr);
      if (v.e_iv) begin
        chk($sformatf("row%0d inst", i),   inst,    v.e_inst);
        chk($sformatf("row%0d ipc", i),    inst_pc, v.e_ipc);
        chk($sformatf("row%0d opcode", i), {12'b0, opcode},   {12'b0, v.e_inst[15:12]});
        chk($sformatf("row%0d func", i),   {10'b0, func_code}, {10'b0, v.e_inst[5:0]});
      end
      @(negedge clk);
    end

    // Async reset mid-request with a stalled valid slot
    inputReady = 1'b0; id_stall = 1'b1; redirect_valid = 1'b0;
    #1;
    chk("pre-rst readM", {15'b0, i_readM},    16'h0001);
    chk("pre-rst ival",  {15'b0, inst_valid}, 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    chk("arst readM", {15'b0, i_readM},    16'h0000);
    chk("arst ival",  {15'b0, inst_valid}, 16'h0000);
    chk("arst inst",  inst,                16'h0000);
    chk("arst addr",  i_address,           16'h0000);
    @(negedge clk);
    reset_n = 1'b1; id_stall = 1'b0;
    #1;
    chk("post-rst readM", {15'b0, i_readM}, 16'h0001);
    chk("post-rst addr",  i_address,        16'h0000);
    inputReady = 1'b1; i_data = 16'h6001;
    @(negedge clk);
    inputReady = 1'b1; i_data = 16'hF01D;
    #1;
    chk("refetch ival", {15'b0, inst_valid}, 16'h0001);
    chk("refetch inst", inst,                16'h6001);
    chk("refetch ipc",  inst_pc,             16'h0000);
    chk("refetch addr", i_address,           16'h0001);

    // Async reset out of HALT
    @(negedge clk);
    inputReady = 1'b0;
    #1;
    chk("halt2 halted", {15'b0, halted},  16'h0001);
    chk("halt2 readM",  {15'b0, i_readM}, 16'h0000);
    #2 reset_n = 1'b0;
    #1;
    chk("arst2 halted", {15'b0, halted},     16'h0000);
    chk("arst2 ival",   {15'b0, inst_valid}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post-rst2 readM", {15'b0, i_readM}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
